pipeline_ifu_stage1: RTL and testbench

PIPELINE_IFU_STAGE1 -- requirements
Module: pipeline_ifu_stage1

---
 rtl/pipeline_ifu_stage1.sv | 165 ++++++++++++++++
 tb/tb_pipeline_ifu_stage1.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ifu_stage1.sv
// Instruction fetch stage 1: issues in-order fetch requests, buffers up to two
// in-flight instructions and presents one registered instruction per cycle to decode.
module pipeline_ifu_stage1 #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IFR,
  output logic        valid_IF
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] ent_pc_q [2];
  logic [63:0] ent_pc_d [2];
  logic [31:0] ent_inst_q [2];
  logic [31:0] ent_inst_d [2];
  logic [1:0]  ent_filled_q, ent_filled_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  discard_q, discard_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic        head_unf, next_unf, head_filled;
  logic        fill_hit, fill_idx, tail_idx;
  logic        alloc, pop;
  logic [1:0]  unfilled_cnt;
  logic        unused_ok;

  // Target bits below word alignment are ignored.
  assign unused_ok = ^redirect_pc[1:0];

  always_comb begin
    head_unf     = (count_q != 2'd0) && !ent_filled_q[head_q];
    next_unf     = (count_q == 2'd2) && !ent_filled_q[~head_q];
    head_filled  = (count_q != 2'd0) && ent_filled_q[head_q];
    unfilled_cnt = {1'b0, head_unf} + {1'b0, next_unf};
    fill_idx     = head_unf ? head_q : ~head_q;
    fill_hit     = imem_rsp_valid && (head_unf || next_unf);
    tail_idx     = head_q ^ count_q[0];
  end

  assign imem_req_valid = (state_q == FETCH) && (count_q != 2'd2) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign alloc          = imem_req_valid && imem_req_ready;
  assign pop            = !redirect_valid && !stall && head_filled;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    ent_pc_d     = ent_pc_q;
    ent_inst_d   = ent_inst_q;
    ent_filled_d = ent_filled_q;
    head_d       = head_q;
    count_d      = count_q;
    discard_d    = discard_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;

    if (redirect_valid) begin
      fetch_pc_d   = {redirect_pc[63:2], 2'b00};
      ent_filled_d = '0;
      head_d       = 1'b0;
      count_d      = '0;
      inst_d       = NOP_INST;
      pc_out_d     = '0;
      valid_d      = 1'b0;
      // A response landing this cycle retires one outstanding request itself.
      if (state_q == DRAIN) begin
        if (imem_rsp_valid && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;
      end else begin
        discard_d = unfilled_cnt - {1'b0, fill_hit};
      end
      state_d = (discard_d != 2'd0) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        DRAIN: begin
          if (imem_rsp_valid && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
            if (discard_q == 2'd1) state_d = FETCH;
          end
        end
        default: state_d = state_q;
      endcase

      if (alloc) begin
        ent_pc_d[tail_idx]     = fetch_pc_q;
        ent_filled_d[tail_idx] = 1'b0;
        fetch_pc_d             = fetch_pc_q + 64'd4;
      end

      if (fill_hit) begin
        ent_inst_d[fill_idx]   = imem_rsp_data;
        ent_filled_d[fill_idx] = 1'b1;
      end

      // Only entries filled in an earlier cycle can reach decode.
      if (!stall) begin
        if (head_filled) begin
          inst_d   = ent_inst_q[head_q];
          pc_out_d = ent_pc_q[head_q];
          valid_d  = 1'b1;
          head_d   = ~head_q;
        end else begin
          inst_d   = NOP_INST;
          pc_out_d = '0;
          valid_d  = 1'b0;
        end
      end

      count_d = count_q + {1'b0, alloc} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      for (int i = 0; i < 2; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
      end
      ent_filled_q <= '0;
      head_q       <= 1'b0;
      count_q      <= '0;
      discard_q    <= '0;
      inst_q       <= NOP_INST;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      ent_pc_q     <= ent_pc_d;
      ent_inst_q   <= ent_inst_d;
      ent_filled_q <= ent_filled_d;
      head_q       <= head_d;
      count_q      <= count_d;
      discard_q    <= discard_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

  assign instruction_IF = inst_q;
  assign pc_IFR         = pc_out_q;
  assign valid_IF       = valid_q;

endmodule

// File: tb/tb_pipeline_ifu_stage1.sv
// Directed bench for pipeline_ifu_stage1 with a 1-cycle in-order memory model.
module tb_pipeline_ifu_stage1;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IFR;
  logic        valid_IF;

  int checks = 0;
  int errors = 0;

  logic [63:0] pend_q[$];
  logic [63:0] acc_q[$];
  logic [63:0] out_pc_q[$];
  logic [31:0] out_inst_q[$];
  logic        mem_hold;
  logic [63:0] exp_pc;
  logic [63:0] next_req_addr;

  pipeline_ifu_stage1 #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instruction_IF(instruction_IF),
    .pc_IFR(pc_IFR), .valid_IF(valid_IF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return 32'h00A0_0093 ^ {a[13:2], 20'h0};
  endfunction

  // One clock: sample handshake before the edge, then record outputs and drive the memory.
  task automatic cycle();
    logic        acc, st;
    logic [63:0] a;
    #2;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    st  = stall || redirect_valid;
    @(posedge clk);
    #1;
    if (acc) begin
      pend_q.push_back(a);
      acc_q.push_back(a);
      next_req_addr = a + 64'd4;
    end
    if (!st && valid_IF) begin
      out_pc_q.push_back(pc_IFR);
      out_inst_q.push_back(instruction_IF);
    end
    if (!mem_hold && pend_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; mem_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid_IF !== 1'b0 || instruction_IF !== NOP_INST || pc_IFR !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b inst=%h pc=%h want 0 %h 0", valid_IF, instruction_IF, pc_IFR, NOP_INST);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    reset = 1'b1;
    exp_pc = RESET_PC;
    next_req_addr = RESET_PC;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: got %b want 0", imem_req_valid);
    end
  endtask

  task automatic test_basic_fetch();
    cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL first_req: got valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    cycle();
    cycle();
    checks++;
    if (valid_IF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_forward_same_cycle: got valid=%b want 0", valid_IF);
    end
    cycle();
    checks++;
    if (valid_IF !== 1'b1 || pc_IFR !== RESET_PC || instruction_IF !== 32'h00A0_0093) begin
      errors++;
      $display("[TB] FAIL first_inst: got valid=%b pc=%h inst=%h want 1 %h 00a00093", valid_IF, pc_IFR, instruction_IF, RESET_PC);
    end
    repeat (8) cycle();
    checks++;
    if (acc_q.size() < 3 || acc_q[0] !== 64'h8000_0000 || acc_q[1] !== 64'h8000_0004 || acc_q[2] !== 64'h8000_0008) begin
      errors++;
      $display("[TB] FAIL req_sequence: got %0d reqs first=%h want 80000000,80000004,80000008", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hx);
    end
    acc_q.delete();
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL basic_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic test_stall();
    logic [63:0] held_pc;
    int          acc_before;
    for (int i = 0; i < 10; i++) begin
      if (valid_IF === 1'b1) break;
      cycle();
    end
    checks++;
    if (valid_IF !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_wait_valid: got valid=%b want 1 within 10 cycles", valid_IF);
    end
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL prestall_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    held_pc = exp_pc - 64'd4;
    acc_before = acc_q.size();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (valid_IF !== 1'b1 || pc_IFR !== held_pc || instruction_IF !== mem_data(held_pc)) begin
        errors++;
        $display("[TB] FAIL stall_hold: got valid=%b pc=%h inst=%h want 1 %h %h", valid_IF, pc_IFR, instruction_IF, held_pc, mem_data(held_pc));
      end
    end
    checks++;
    if (acc_q.size() - acc_before > 2) begin
      errors++;
      $display("[TB] FAIL stall_req_limit: got %0d accepted want <=2", acc_q.size() - acc_before);
    end
    stall = 1'b0;
    repeat (12) cycle();
    checks++;
    if (out_pc_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL stall_resume: got 0 instructions want >0");
    end
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL poststall_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    acc_q.delete();
  endtask

  task automatic test_redirect();
    mem_hold = 1'b1;
    repeat (6) cycle();
    checks++;
    if (pend_q.size() != 2 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_setup: got outstanding=%0d req_valid=%b want 2 0", pend_q.size(), imem_req_valid);
    end
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL preredirect_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    mem_hold = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0102;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (valid_IF !== 1'b0 || instruction_IF !== NOP_INST || pc_IFR !== 64'd0) begin
      errors++;
      $display("[TB] FAIL redirect_bubble: got valid=%b inst=%h pc=%h want 0 %h 0", valid_IF, instruction_IF, pc_IFR, NOP_INST);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_no_req: got %b want 0", imem_req_valid);
    end
    acc_q.delete();
    exp_pc = 64'h8000_0100;
    repeat (10) cycle();
    checks++;
    if (acc_q.size() == 0 || acc_q[0] !== 64'h8000_0100) begin
      errors++;
      $display("[TB] FAIL redirect_req_addr: got %0d reqs first=%h want 80000100", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hx);
    end
    checks++;
    if (out_pc_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL redirect_resume: got 0 instructions want >0");
    end
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL postredirect_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    acc_q.delete();
  endtask

  task automatic test_redirect_stall_rsp();
    mem_hold = 1'b1;
    repeat (6) cycle();
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL prestallredir_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    stall = 1'b1;
    mem_hold = 1'b0;
    cycle();
    checks++;
    if (imem_rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stallredir_setup: got rsp_valid=%b want 1", imem_rsp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (valid_IF !== 1'b0 || instruction_IF !== NOP_INST || pc_IFR !== 64'd0) begin
      errors++;
      $display("[TB] FAIL stallredir_bubble: got valid=%b inst=%h pc=%h want 0 %h 0", valid_IF, instruction_IF, pc_IFR, NOP_INST);
    end
    stall = 1'b0;
    acc_q.delete();
    exp_pc = 64'h8000_0200;
    repeat (10) cycle();
    checks++;
    if (acc_q.size() == 0 || acc_q[0] !== 64'h8000_0200) begin
      errors++;
      $display("[TB] FAIL stallredir_req_addr: got %0d reqs first=%h want 80000200", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hx);
    end
    checks++;
    if (out_pc_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL stallredir_resume: got 0 instructions want >0");
    end
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL stallredir_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    acc_q.delete();
  endtask

  task automatic test_ready_low();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 3) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== next_req_addr) begin
          errors++;
          $display("[TB] FAIL ready_low_hold: got valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, next_req_addr);
        end
      end
    end
    checks++;
    if (valid_IF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_low_drained: got valid=%b want 0", valid_IF);
    end
    imem_req_ready = 1'b1;
    repeat (8) cycle();
    while (out_pc_q.size() > 0) begin
      logic [63:0] p;
      logic [31:0] d;
      p = out_pc_q.pop_front();
      d = out_inst_q.pop_front();
      checks++;
      if (p !== exp_pc || d !== mem_data(exp_pc)) begin
        errors++;
        $display("[TB] FAIL ready_low_stream: got pc=%h inst=%h want %h %h", p, d, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
    end
    acc_q.delete();
  endtask

  task automatic test_reset_mid();
    mem_hold = 1'b1;
    repeat (3) cycle();
    checks++;
    if (pend_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_setup: got 0 outstanding want >0");
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_IF !== 1'b0 || instruction_IF !== NOP_INST || pc_IFR !== 64'd0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got valid=%b inst=%h pc=%h req=%b want 0 %h 0 0", valid_IF, instruction_IF, pc_IFR, imem_req_valid, NOP_INST);
    end
    pend_q.delete(); acc_q.delete(); out_pc_q.delete(); out_inst_q.delete();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_pc = RESET_PC;
    next_req_addr = RESET_PC;
    repeat (8) cycle();
    checks++;
    if (acc_q.size() == 0 || acc_q[0] !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_mid_restart: got %0d reqs first=%h want %h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hx, RESET_PC);
    end
    checks++;
    if (out_pc_q.size() == 0 || out_pc_q[0] !== RESET_PC || out_inst_q[0] !== 32'h00A0_0093) begin
      errors++;
      $display("[TB] FAIL reset_mid_first_inst: got %0d insts first pc=%h want %h inst 00a00093", out_pc_q.size(), (out_pc_q.size() > 0) ? out_pc_q[0] : 64'hx, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_redirect_stall_rsp();
    test_ready_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
